// File: rtl/instr_prefetch.sv
// instr_prefetch: RV32I instruction prefetch unit.
//   Owns the fetch PC and issues one word read at a time to instruction
//   memory (req/ack). Returned words are buffered with their PCs in a
//   DEPTH-entry FIFO and presented to decode via a valid/ready handshake.
//   A redirect clears the FIFO and retargets fetching. A request that is
//   already in flight is drained and its data dropped.
//
// Parameters:
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   mem_req      fetch request, held until mem_ack
//   mem_addr     word-aligned fetch address, stable while mem_req=1
//   mem_ack      mem_rdata valid / request complete
//   mem_rdata    returned instruction word
//   redirect     one-cycle pulse: discard buffered and in-flight fetches
//   redirect_pc  new fetch address, sampled with redirect
//   instr_valid  FIFO non-empty
//   instr        head instruction word
//   instr_pc     PC of head instruction
//   instr_ready  decode accepts the head entry this cycle
//   fetch_fault  (IFETCH_ALIGN_CHK_EN only) sticky misaligned-redirect flag
//
// Build option: define IFETCH_ALIGN_CHK_EN to trap misaligned redirects.
// Without it, redirect_pc[1:0] is ignored.
module instr_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
`ifdef IFETCH_ALIGN_CHK_EN
  , output logic      fetch_fault
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FLUSH} state_t;

  state_t        r_state, w_state_next;
  logic [31:0]   r_fetch_pc, w_fetch_next;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_word [DEPTH];
  logic [31:0]   r_pc   [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_count, w_count_next;
  logic          r_fault;
  logic          w_push, w_pop, w_room, w_stop, w_fault_set;
  logic [31:0]   w_redir_pc;

`ifdef IFETCH_ALIGN_CHK_EN
  assign w_fault_set = redirect && (redirect_pc[1:0] != 2'b00);
  assign fetch_fault = r_fault;
`else
  assign w_fault_set = 1'b0;
`endif

  assign w_redir_pc  = redirect_pc & 32'hFFFF_FFFC;
  assign w_stop      = r_fault | w_fault_set;

  assign mem_req     = (r_state != ST_IDLE);
  assign mem_addr    = r_mem_addr;
  assign instr_valid = (r_count != '0);
  assign instr       = r_word[r_rd];
  assign instr_pc    = r_pc[r_rd];

  always_comb begin
    w_pop        = instr_valid && instr_ready;
    w_push       = (r_state == ST_WAIT) && mem_ack && !redirect;
    w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    w_room       = (w_count_next < CW'(DEPTH));

    w_state_next = r_state;
    w_fetch_next = r_fetch_pc;
    if (redirect) begin
      w_fetch_next = w_redir_pc;
      // An outstanding request cannot be withdrawn: drain it first.
      if (r_state != ST_IDLE && !mem_ack) w_state_next = ST_FLUSH;
      else                                w_state_next = ST_WAIT;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_room) w_state_next = ST_WAIT;
        ST_WAIT:  if (mem_ack) begin
                    w_fetch_next = r_fetch_pc + 32'd4;
                    w_state_next = w_room ? ST_WAIT : ST_IDLE;
                  end
        ST_FLUSH: if (mem_ack) w_state_next = ST_WAIT;
        default:  w_state_next = ST_IDLE;
      endcase
    end
    // After a fault no new request is issued; a draining one still completes.
    if (w_stop && w_state_next == ST_WAIT) w_state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_mem_addr <= RESET_PC;
      r_rd       <= '0;
      r_wr       <= '0;
      r_count    <= '0;
      r_fault    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_word[i] <= '0;
        r_pc[i]   <= '0;
      end
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_next;
      // fetch_pc jumps to the redirect target at once, but the bus address
      // of a draining request must stay put until its ack.
      if (w_state_next != ST_FLUSH) r_mem_addr <= w_fetch_next;
      r_fault <= r_fault | w_fault_set;
      if (redirect) begin
        r_rd    <= '0;
        r_wr    <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_word[r_wr] <= mem_rdata;
          r_pc[r_wr]   <= r_fetch_pc;
          r_wr         <= r_wr + AW'(1);
        end
        if (w_pop) r_rd <= r_rd + AW'(1);
        r_count <= w_count_next;
      end
    end
  end

endmodule
